maxpool2x2_stream: RTL and testbench

//   Streaming 2x2 / stride-2 max-pooling engine for one feature-map channel.

---
 rtl/maxpool_pkg.sv | 31 +++
 rtl/maxpool2x2_stream_if.sv | 27 ++
 rtl/maxpool2x2_stream_pool_max2.sv | 25 ++
 rtl/maxpool2x2_stream.sv | 189 ++++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 max-pooling stream engine:
// default pixel width, argmax position codes, row-phase enum and
// a constant-friendly ceil(log2) used to size the position counters.
package maxpool_pkg;

  localparam int DATA_W_DEF = 32;

  // Argmax window positions
  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } phase_t;

  // Bits needed to index v entries; never less than 1 so counters stay legal
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel-in / pooled-value-out handshake bundle for maxpool2x2_stream.
// master = the side that feeds pixels and drains results, slave = the engine.
interface maxpool2x2_stream_if
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        out_idx;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );
endinterface

// File: rtl/maxpool2x2_stream_pool_max2.sv
// pool_max2: combinational two-input maximum.
// sel=0 picks a, sel=1 picks b; b only wins when strictly greater, so on a
// tie the earlier operand (a) is kept. SIGNED selects two's-complement order.
module pool_max2 #(
  parameter int DATA_W = 32,
  parameter int SIGNED = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] max_val,
  output logic              sel
);

  // Strict greater-than compare in the configured number system
  always_comb begin
    sel = 1'b0;
    if (SIGNED != 0) begin
      sel = ($signed(b) > $signed(a));
    end else begin
      sel = (b > a);
    end
    max_val = sel ? b : a;
  end

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 max pooling of one channel.
// Raster pixels come in one per handshake; even rows store horizontal pair
// maxima in a half-width line buffer, odd rows combine them with the current
// pair and emit one pooled value per window.
// Optional build macro: MAXPOOL_ARGMAX_EN drives out_idx with the winning
// window position (line buffer keeps one extra bit for the top-row winner).
module maxpool2x2_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIGNED = 1,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input logic          clk,
  input logic          rst,
  maxpool2x2_stream_if.slave bus
);

  localparam int HALF_W   = IMG_W / 2;
  localparam int COL_W    = clog2(IMG_W);
  localparam int ROW_W    = clog2(IMG_H);
  localparam int LB_AW    = clog2(HALF_W);
  localparam int LAST_COL = IMG_W - 1;
  localparam int LAST_ROW = IMG_H - 1;
  // Row of the final window: an odd trailing row never closes a window
  localparam int LAST_OUT_ROW = IMG_H - 1 - (IMG_H % 2);
`ifdef MAXPOOL_ARGMAX_EN
  localparam int LB_W = DATA_W + 1;
`else
  localparam int LB_W = DATA_W;
`endif

  logic [COL_W-1:0]  col_r, col_eff_s, col_nxt_s;
  logic [ROW_W-1:0]  row_r, row_eff_s, row_nxt_s;
  phase_t            phase_r, phase_eff_s, phase_nxt_s;
  logic [DATA_W-1:0] h_reg_r;
  logic [LB_W-1:0]   lbuf_r [HALF_W];

  logic              accept_s;
  logic              odd_col_s;
  logic              close_s;
  logic              write_s;
  logic              last_s;
  logic [LB_AW-1:0]  lb_addr_s;
  logic [LB_W-1:0]   lb_rd_s;
  logic [LB_W-1:0]   lb_wr_s;
  logic [DATA_W-1:0] top_data_s;
  logic [DATA_W-1:0] hmax_s;
  logic [DATA_W-1:0] vmax_s;
  logic              hsel_s;
  logic              vsel_s;
  logic [1:0]        idx_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic [1:0]        out_idx_r;

  assign bus.in_ready  = ~out_valid_r | bus.out_ready;
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

  // Position of the current pixel: start-of-frame overrides the counters
  always_comb begin
    col_eff_s   = col_r;
    row_eff_s   = row_r;
    phase_eff_s = phase_r;
    if (bus.in_sof) begin
      col_eff_s   = '0;
      row_eff_s   = '0;
      phase_eff_s = EVEN_ROW;
    end else begin
      col_eff_s   = col_r;
      row_eff_s   = row_r;
      phase_eff_s = phase_r;
    end
  end

  assign odd_col_s  = col_eff_s[0];
  assign lb_addr_s  = LB_AW'(col_eff_s >> 1);
  assign lb_rd_s    = lbuf_r[lb_addr_s];
  assign top_data_s = lb_rd_s[DATA_W-1:0];
  // Even rows only write the line buffer, odd rows only read it, so the two
  // ports can never collide on one entry.
  assign write_s    = accept_s & odd_col_s & (phase_eff_s == EVEN_ROW);
  assign close_s    = accept_s & odd_col_s & (phase_eff_s == ODD_ROW);
  assign last_s     = (row_eff_s == ROW_W'(LAST_OUT_ROW)) &&
                      (lb_addr_s == LB_AW'(HALF_W - 1));

  // Horizontal pair: left pixel (held) versus the current right pixel
  pool_max2 #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_hmax (
    .a       (h_reg_r),
    .b       (bus.in_data),
    .max_val (hmax_s),
    .sel     (hsel_s)
  );

  // Vertical pair: stored top-row maximum versus the bottom-row maximum
  pool_max2 #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_vmax (
    .a       (top_data_s),
    .b       (hmax_s),
    .max_val (vmax_s),
    .sel     (vsel_s)
  );

`ifdef MAXPOOL_ARGMAX_EN
  logic top_sel_s;
  assign top_sel_s     = lb_rd_s[DATA_W];
  assign lb_wr_s       = {hsel_s, hmax_s};
  assign idx_s         = vsel_s ? (hsel_s    ? IDX_BR : IDX_BL)
                                : (top_sel_s ? IDX_TR : IDX_TL);
  assign bus.out_idx   = out_idx_r;
`else
  logic unused_sel_s;
  assign unused_sel_s  = ^{hsel_s, vsel_s, out_idx_r};
  assign lb_wr_s       = hmax_s;
  assign idx_s         = IDX_TL;
  assign bus.out_idx   = 2'b00;
`endif

  // Raster advance: column wraps into the next row, last row wraps the frame
  always_comb begin
    col_nxt_s   = col_eff_s + COL_W'(1);
    row_nxt_s   = row_eff_s;
    phase_nxt_s = phase_eff_s;
    if (col_eff_s == COL_W'(LAST_COL)) begin
      col_nxt_s = '0;
      if (row_eff_s == ROW_W'(LAST_ROW)) begin
        row_nxt_s   = '0;
        phase_nxt_s = EVEN_ROW;
      end else begin
        row_nxt_s   = row_eff_s + ROW_W'(1);
        phase_nxt_s = (phase_eff_s == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end
    end else begin
      col_nxt_s = col_eff_s + COL_W'(1);
    end
  end

  // Position counters and row phase, updated on every accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r   <= '0;
      row_r   <= '0;
      phase_r <= EVEN_ROW;
    end else if (accept_s) begin
      col_r   <= col_nxt_s;
      row_r   <= row_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // Hold the left pixel of each horizontal pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg_r <= '0;
    end else if (accept_s && !odd_col_s) begin
      h_reg_r <= bus.in_data;
    end
  end

  // Line buffer of top-row pair maxima; contents survive reset by design
  always_ff @(posedge clk) begin
    if (write_s) begin
      lbuf_r[lb_addr_s] <= lb_wr_s;
    end
  end

  // Output register: load on window close, otherwise clear once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_idx_r   <= 2'b00;
    end else if (close_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= vmax_s;
      out_last_r  <= last_s;
      out_idx_r   <= idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: three engines (4x4 signed,
// 4x4 unsigned, 5x5 signed) fed from a table of window vectors plus
// hand-written raster, backpressure, reset and resync sequences.
// Expected results are queued when the closing pixel is accepted and
// compared when the engine hands the pooled value over.
module tb_maxpool2x2_stream;
  import maxpool_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  idx;
  } exp_t;

  typedef struct {
    int                d;
    logic [3:0][31:0]  px;
    logic [31:0]       exp_data;
    logic [1:0]        exp_idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t vecs[10];

  maxpool2x2_stream_if #(.DATA_W(32)) ifa ();
  maxpool2x2_stream_if #(.DATA_W(32)) ifb ();
  maxpool2x2_stream_if #(.DATA_W(32)) ifc ();

  maxpool2x2_stream #(.DATA_W(32), .SIGNED(1), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  maxpool2x2_stream #(.DATA_W(32), .SIGNED(0), .IMG_W(4), .IMG_H(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));
  maxpool2x2_stream #(.DATA_W(32), .SIGNED(1), .IMG_W(5), .IMG_H(5)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] dv, input logic l, input logic [1:0] ix);
    exp_t e;
    e.data = dv;
    e.last = l;
`ifdef MAXPOOL_ARGMAX_EN
    e.idx = ix;
`else
    e.idx = 2'b00;
`endif
    return e;
  endfunction

  function automatic logic get_iready(input int d);
    case (d)
      0: return ifa.in_ready;
      1: return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  function automatic logic get_ovalid(input int d);
    case (d)
      0: return ifa.out_valid;
      1: return ifb.out_valid;
      default: return ifc.out_valid;
    endcase
  endfunction

  function automatic exp_t get_out(input int d);
    exp_t e;
    case (d)
      0: begin e.data = ifa.out_data; e.last = ifa.out_last; e.idx = ifa.out_idx; end
      1: begin e.data = ifb.out_data; e.last = ifb.out_last; e.idx = ifb.out_idx; end
      default: begin e.data = ifc.out_data; e.last = ifc.out_last; e.idx = ifc.out_idx; end
    endcase
    return e;
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input int d, input logic v, input logic sof,
                       input logic [31:0] dat, input logic ordy);
    case (d)
      0: begin ifa.in_valid = v; ifa.in_sof = sof; ifa.in_data = dat; ifa.out_ready = ordy; end
      1: begin ifb.in_valid = v; ifb.in_sof = sof; ifb.in_data = dat; ifb.out_ready = ordy; end
      default: begin ifc.in_valid = v; ifc.in_sof = sof; ifc.in_data = dat; ifc.out_ready = ordy; end
    endcase
  endtask

  // One clock: drive at negedge, sample 1 ns later, score handovers
  task automatic step(input int d, input logic v, input logic sof, input logic [31:0] dat,
                      input logic ordy, input logic push, input exp_t e,
                      output logic acc, output logic ov);
    exp_t got;
    exp_t want;
    @(negedge clk);
    drive(d, v, sof, dat, ordy);
    #1;
    ov  = get_ovalid(d);
    acc = v & get_iready(d);
    if (ov && ordy) begin
      got = get_out(d);
      if (q_size(d) == 0) begin
        n_total++;
        $display("FAIL unexpected_output dut%0d: got %h expected none", d, got.data);
      end else begin
        want = q_pop(d);
        chk("out_data", got.data, want.data);
        chk("out_last", 32'(got.last), 32'(want.last));
        chk("out_idx", 32'(got.idx), 32'(want.idx));
      end
    end
    if (acc && push) q_push(d, e);
  endtask

  task automatic send(input int d, input logic [31:0] dat, input logic sof,
                      input logic push, input exp_t e);
    logic acc;
    logic ov;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(d, 1'b1, sof, dat, 1'b1, push, e, acc, ov);
      tries++;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout dut%0d: got no accept expected accept", d);
    end
  endtask

  task automatic idle(input int d, input int n);
    logic acc;
    logic ov;
    for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(32'd0, 1'b0, 2'd0), acc, ov);
  endtask

  task automatic drain(input int d);
    idle(d, 8);
    chk("queue_empty", 32'(q_size(d)), 32'd0);
  endtask

  task automatic set_vec(input int i, input int d, input logic [31:0] tl, input logic [31:0] tr,
                         input logic [31:0] bl, input logic [31:0] br,
                         input logic [31:0] ed, input logic [1:0] ei);
    vecs[i].d = d;
    vecs[i].px[0] = tl;
    vecs[i].px[1] = tr;
    vecs[i].px[2] = bl;
    vecs[i].px[3] = br;
    vecs[i].exp_data = ed;
    vecs[i].exp_idx = ei;
  endtask

  // 4x4 frame whose four windows all repeat one vector
  task automatic frame_vec(input int i);
    int d;
    d = vecs[i].d;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(d, vecs[i].px[(r % 2) * 2 + (c % 2)], (r == 0 && c == 0),
             (r % 2 == 1 && c % 2 == 1),
             mk(vecs[i].exp_data, (r == 3 && c == 3), vecs[i].exp_idx));
      end
    end
    drain(d);
  endtask

  function automatic logic close4(input int p);
    return ((p / 4) % 2 == 1) && (p % 2 == 1);
  endfunction

  function automatic logic [31:0] pix5(input int r, input int c, input int off);
    return (r == 4 || c == 4) ? 32'd1000 : 32'(r * 5 + c + off);
  endfunction

  initial begin
    logic acc;
    logic ov;
    logic prev;

    set_vec(0, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'hFFFFFFFF, IDX_TR);
    set_vec(1, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'hFFFFFFFF, IDX_TR);
    set_vec(2, 0, 32'd5, 32'h80000000, 32'd7, 32'd3, 32'd7, IDX_BL);
    set_vec(3, 1, 32'd5, 32'h80000000, 32'd7, 32'd3, 32'h80000000, IDX_TR);
    set_vec(4, 0, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, IDX_TL);
    set_vec(5, 0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, IDX_BR);
    set_vec(6, 0, 32'd4, 32'd3, 32'd2, 32'd1, 32'd4, IDX_TL);
    set_vec(7, 0, 32'd1, 32'd5, 32'd5, 32'd2, 32'd5, IDX_TR);
    set_vec(8, 0, 32'd2, 32'd1, 32'd7, 32'd7, 32'd7, IDX_BL);
    set_vec(9, 1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, IDX_BR);

    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", 32'(get_ovalid(d)), 32'd0);
      chk("reset_out_data", get_out(d).data, 32'd0);
      chk("reset_in_ready", 32'(get_iready(d)), 32'd1);
    end
    rst = 1'b0;

    // Raster 0..15: outputs 5,7,13,15, each visible one cycle after its pixel
    prev = 1'b0;
    for (int p = 0; p <= 16; p++) begin
      if (p < 16) step(0, 1'b1, (p == 0), 32'(p), 1'b1, close4(p), mk(32'(p), (p == 15), IDX_BR), acc, ov);
      else        step(0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(32'd0, 1'b0, 2'd0), acc, ov);
      chk("raster_accept", 32'(acc), 32'(p < 16));
      chk("raster_latency", 32'(ov), 32'(prev));
      prev = (p < 16) && close4(p);
    end
    drain(0);

    // Window vectors: sign handling, unsigned order, tie rules
    for (int i = 0; i < 10; i++) frame_vec(i);

    // Backpressure: hold the first result for 5 cycles
    for (int p = 0; p < 6; p++) send(0, 32'(100 + p), (p == 0), close4(p), mk(32'(100 + p), 1'b0, IDX_BR));
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b1, 1'b0, 32'd106, 1'b0, 1'b0, mk(32'd0, 1'b0, 2'd0), acc, ov);
      chk("stall_accept", 32'(acc), 32'd0);
      chk("stall_in_ready", 32'(get_iready(0)), 32'd0);
      chk("stall_out_valid", 32'(ov), 32'd1);
      chk("stall_out_data", get_out(0).data, 32'd105);
    end
    for (int p = 6; p < 16; p++) send(0, 32'(100 + p), 1'b0, close4(p), mk(32'(100 + p), (p == 15), IDX_BR));
    drain(0);

    // 5x5 frames: last column and last row dropped, 4 outputs each, wrap without sof
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          send(2, pix5(r, c, f * 50), (f == 0 && r == 0 && c == 0),
               ((r == 1 || r == 3) && (c == 1 || c == 3)),
               mk(pix5(r, c, f * 50), (r == 3 && c == 3), IDX_BR));
        end
      end
    end
    drain(2);

    // Reset mid-row-1 with a result pending: result dropped, new frame clean
    for (int p = 0; p < 6; p++) send(0, 32'(300 + p), (p == 0), close4(p), mk(32'(300 + p), 1'b0, IDX_BR));
    step(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(32'd0, 1'b0, 2'd0), acc, ov);
    chk("pending_before_rst", 32'(ov), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(get_ovalid(0)), 32'd0);
    chk("midrst_out_data", get_out(0).data, 32'd0);
    chk("midrst_out_last", 32'(get_out(0).last), 32'd0);
    chk("midrst_out_idx", 32'(get_out(0).idx), 32'd0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 16; p++) send(0, 32'(200 + p), (p == 0), close4(p), mk(32'(200 + p), (p == 15), IDX_BR));
    drain(0);

    // sof in mid-frame discards the partial window and restarts the raster
    for (int p = 0; p < 7; p++) send(0, 32'(500 + p), (p == 0), close4(p), mk(32'(500 + p), 1'b0, IDX_BR));
    for (int p = 0; p < 16; p++) send(0, 32'(400 + p), (p == 0), close4(p), mk(32'(400 + p), (p == 15), IDX_BR));
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
